// File: rtl/pattern_pkg.sv
// Shared encodings for the serial "011"/"110" pattern recogniser:
// state codes, the park code, the two patterns and the fill limit.
package pattern_pkg;

  localparam logic [1:0] ST_00     = 2'b00;
  localparam logic [1:0] ST_01     = 2'b01;
  localparam logic [1:0] ST_10     = 2'b10;
  localparam logic [1:0] ST_11     = 2'b11;

  // 10 cannot form either pattern, so it is safe to present while idle
  localparam logic [1:0] PARK_ST   = ST_10;

  localparam logic [2:0] PATTERN_A = 3'b011;
  localparam logic [2:0] PATTERN_B = 3'b110;

  localparam logic [1:0] FILL_FULL = 2'd2;

endpackage

// File: rtl/pattern_state_reg_match_fn.sv
// Combinational Mealy output function: flags {s, inp} equal to "011" or "110".
// It is used by the optional match counter.
module pattern_match_fn
  import pattern_pkg::*;
(
  input  logic [1:0] i_s,
  input  logic       i_inp,
  output logic       o_match
);

  assign o_match = ({i_s, i_inp} == PATTERN_A) || ({i_s, i_inp} == PATTERN_B);

endmodule

// File: rtl/pattern_state_reg.sv
// State register feeding the registered Mealy output stage of the pattern recogniser.
// Define PATTERN_STATE_CNT_EN to build the saturating match counter on match_cnt.
module pattern_state_reg
  import pattern_pkg::*;
#(
  parameter logic [1:0] PARK_ST = pattern_pkg::PARK_ST,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic [1:0]       s,
  output logic             inp,
  output logic             s_live,
  output logic [CNT_W-1:0] match_cnt
);

  logic [1:0] r_hist;
  logic [1:0] r_fill;
  logic [1:0] r_s;
  logic       r_inp;
  logic       r_live;

  // Anything other than a real accept with full history presents the park state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hist <= 2'b00;
      r_fill <= 2'd0;
      r_s    <= PARK_ST;
      r_inp  <= 1'b0;
      r_live <= 1'b0;
    end else if (in_valid) begin
      r_inp  <= in_bit;
      r_hist <= {r_hist[0], in_bit};
      if (r_fill == FILL_FULL) begin
        r_s    <= r_hist;
        r_live <= 1'b1;
      end else begin
        r_s    <= PARK_ST;
        r_live <= 1'b0;
        r_fill <= r_fill + 2'd1;
      end
    end else begin
      r_s    <= PARK_ST;
      r_inp  <= 1'b0;
      r_live <= 1'b0;
    end
  end

  assign s      = r_s;
  assign inp    = r_inp;
  assign s_live = r_live;

`ifdef PATTERN_STATE_CNT_EN
  logic             w_hit;
  logic [CNT_W-1:0] r_cnt;

  // Same decision the output stage will make one cycle later; clr leaves it alone.
  pattern_match_fn u_match_fn (
    .i_s     (r_hist),
    .i_inp   (in_bit),
    .o_match (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid && !clr && (r_fill == FILL_FULL) && w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_state_reg.sv
// Randomised and directed bench for pattern_state_reg against a queue-based
// model of the accepted bit stream (counter checks follow PATTERN_STATE_CNT_EN).
module tb_pattern_state_reg;

  localparam int         CNT_W = 2;
  localparam logic [1:0] PARK  = 2'b10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clr = 1'b0;
  logic [1:0]       s;
  logic             inp;
  logic             s_live;
  logic [CNT_W-1:0] match_cnt;

  pattern_state_reg #(.PARK_ST(PARK), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr       (clr),
    .s         (s),
    .inp       (inp),
    .s_live    (s_live),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits accepted since the last reset/clear
  bit         acc_q[$];
  logic [1:0] exp_s    = PARK;
  logic       exp_inp  = 1'b0;
  logic       exp_live = 1'b0;
  int         exp_cnt  = 0;
  int         obs_matches = 0;

  function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef PATTERN_STATE_CNT_EN
    return CNT_W'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  // Drive one cycle, advance the model and tally matches the output stage would flag.
  task automatic drive(input bit r, input bit c, input bit v, input bit b);
    @(negedge clk);
    rst = r; clr = c; in_valid = v; in_bit = b;
    @(posedge clk);
    #1;
    if (r || c) begin
      acc_q.delete();
      exp_s = PARK; exp_inp = 1'b0; exp_live = 1'b0;
      if (r) exp_cnt = 0;
    end else if (v) begin
      exp_inp = b;
      if (acc_q.size() >= 2) begin
        exp_s    = {acc_q[$-1], acc_q[$]};
        exp_live = 1'b1;
        if ({exp_s, b} == 3'b011 || {exp_s, b} == 3'b110)
          if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      end else begin
        exp_s = PARK; exp_live = 1'b0;
      end
      acc_q.push_back(b);
    end else begin
      exp_s = PARK; exp_inp = 1'b0; exp_live = 1'b0;
    end
    if (s_live && ((s == 2'b01 && inp) || (s == 2'b11 && !inp))) obs_matches++;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 1);
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({s, inp, s_live, match_cnt} !== {PARK, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset: got s=%b inp=%b live=%b cnt=%0d, want s=10 inp=0 live=0 cnt=0",
               s, inp, s_live, match_cnt);
    end
  endtask

  task automatic test_fill_masking();
    bit seq [3] = '{1, 1, 0};
    drive(1, 0, 0, 0);
    obs_matches = 0;
    foreach (seq[i]) begin
      drive(0, 0, 1, seq[i]);
      n_cmp++;
      if ({s, inp, s_live, match_cnt} !== {exp_s, exp_inp, exp_live, cnt_exp()}) begin
        n_err++;
        $display("FAIL fill step %0d: got s=%b inp=%b live=%b cnt=%0d, want s=%b inp=%b live=%b cnt=%0d",
                 i, s, inp, s_live, match_cnt, exp_s, exp_inp, exp_live, cnt_exp());
      end
    end
    n_cmp++;
    if ({s, inp, s_live} !== 4'b1101 || obs_matches != 1) begin
      n_err++;
      $display("FAIL fill final: got s=%b inp=%b live=%b matches=%0d, want s=11 inp=0 live=1 matches=1",
               s, inp, s_live, obs_matches);
    end
  endtask

  task automatic test_overlap();
    bit seq [4] = '{0, 1, 1, 0};
    drive(1, 0, 0, 0);
    obs_matches = 0;
    foreach (seq[i]) begin
      drive(0, 0, 1, seq[i]);
      n_cmp++;
      if ({s, inp, s_live, match_cnt} !== {exp_s, exp_inp, exp_live, cnt_exp()}) begin
        n_err++;
        $display("FAIL overlap step %0d: got s=%b inp=%b live=%b cnt=%0d, want s=%b inp=%b live=%b cnt=%0d",
                 i, s, inp, s_live, match_cnt, exp_s, exp_inp, exp_live, cnt_exp());
      end
    end
    n_cmp++;
`ifdef PATTERN_STATE_CNT_EN
    if (obs_matches != 2 || match_cnt !== 2'd2) begin
`else
    if (obs_matches != 2 || match_cnt !== 2'd0) begin
`endif
      n_err++;
      $display("FAIL overlap total: got matches=%0d cnt=%0d, want matches=2", obs_matches, match_cnt);
    end
  endtask

  task automatic test_gaps();
    bit vv [7] = '{1, 0, 0, 0, 1, 0, 1};
    bit bb [7] = '{0, 1, 1, 0, 1, 1, 1};
    drive(1, 0, 0, 0);
    obs_matches = 0;
    foreach (vv[i]) begin
      drive(0, 0, vv[i], bb[i]);
      n_cmp++;
      if ({s, inp, s_live, match_cnt} !== {exp_s, exp_inp, exp_live, cnt_exp()}) begin
        n_err++;
        $display("FAIL gaps step %0d: got s=%b inp=%b live=%b cnt=%0d, want s=%b inp=%b live=%b cnt=%0d",
                 i, s, inp, s_live, match_cnt, exp_s, exp_inp, exp_live, cnt_exp());
      end
    end
    n_cmp++;
    if ({s, inp, s_live} !== 4'b0111 || obs_matches != 1) begin
      n_err++;
      $display("FAIL gaps final: got s=%b inp=%b live=%b matches=%0d, want s=01 inp=1 live=1 matches=1",
               s, inp, s_live, obs_matches);
    end
  endtask

  task automatic test_clr();
    bit cc [5] = '{0, 0, 1, 0, 0};
    bit bb [5] = '{0, 1, 1, 1, 0};
    drive(1, 0, 0, 0);
    obs_matches = 0;
    foreach (cc[i]) begin
      drive(0, cc[i], 1, bb[i]);
      n_cmp++;
      if ({s, inp, s_live, match_cnt} !== {exp_s, exp_inp, exp_live, cnt_exp()} ||
          (i >= 2 && s !== PARK)) begin
        n_err++;
        $display("FAIL clr step %0d: got s=%b inp=%b live=%b cnt=%0d, want s=%b inp=%b live=%b cnt=%0d",
                 i, s, inp, s_live, match_cnt, exp_s, exp_inp, exp_live, cnt_exp());
      end
    end
    n_cmp++;
    if (obs_matches != 0) begin
      n_err++;
      $display("FAIL clr matches: got %0d, want 0", obs_matches);
    end
  endtask

  task automatic test_saturation();
    bit seq [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    drive(1, 0, 0, 0);
    foreach (seq[i]) drive(0, 0, 1, seq[i]);
    n_cmp++;
`ifdef PATTERN_STATE_CNT_EN
    if (match_cnt !== 2'd3) begin
`else
    if (match_cnt !== 2'd0) begin
`endif
      n_err++;
      $display("FAIL saturation: got cnt=%0d, want %0d", match_cnt, cnt_exp());
    end
    drive(0, 1, 0, 0);
    n_cmp++;
    if (match_cnt !== cnt_exp()) begin
      n_err++;
      $display("FAIL cnt_after_clr: got cnt=%0d, want %0d", match_cnt, cnt_exp());
    end
    drive(1, 0, 0, 0);
    n_cmp++;
    if (match_cnt !== '0) begin
      n_err++;
      $display("FAIL cnt_after_rst: got cnt=%0d, want 0", match_cnt);
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({s, inp, s_live, match_cnt} !== {exp_s, exp_inp, exp_live, cnt_exp()}) begin
        n_err++;
        $display("FAIL random step %0d: got s=%b inp=%b live=%b cnt=%0d, want s=%b inp=%b live=%b cnt=%0d",
                 i, s, inp, s_live, match_cnt, exp_s, exp_inp, exp_live, cnt_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_masking();
    test_overlap();
    test_gaps();
    test_clr();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
